// File: rtl/wb_cmd_master.sv
// wb_cmd_master: turns single request/response commands into Wishbone B3
// classic single transfers. A request is accepted only from IDLE, run on the
// bus until the slave acks or the wait budget runs out, and then held as a
// response until the consumer takes it. Every output is a register.
module wb_cmd_master #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  // request channel
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_dat,
  input  logic [3:0]  req_sel,
  // response channel
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  // Wishbone master side
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Last count value of the bus wait; reaching it without an ack aborts.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 32'd1);

  state_t     state_r;
  logic [7:0] cnt_r;

  // Transfer sequencer: the request fields are latched straight into the bus
  // registers, so they stay stable for the whole bus phase whatever req_*
  // does afterwards. Leaving RESP lands in IDLE with req_ready still low,
  // which gives the one-cycle gap between transfers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r   <= IDLE;
      cnt_r     <= 8'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_dat   <= 32'd0;
      rsp_err   <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= 4'd0;
      wbm_adr_o <= 32'd0;
      wbm_dat_o <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_ready && req_valid) begin
            req_ready <= 1'b0;
            wbm_we_o  <= req_we;
            wbm_adr_o <= req_adr;
            wbm_dat_o <= req_dat;
            wbm_sel_o <= req_sel;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            cnt_r     <= 8'd0;
            state_r   <= BUS;
          end else begin
            req_ready <= 1'b1;
          end
        end
        BUS: begin
          // An ack wins over a timeout that expires in the same cycle.
          if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_dat   <= wbm_we_o ? 32'd0 : wbm_dat_i;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state_r   <= RESP;
          end else if (cnt_r == CNT_LAST) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_dat   <= 32'd0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state_r   <= RESP;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_r   <= IDLE;
          end else begin
            rsp_valid <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          req_ready <= 1'b0;
          rsp_valid <= 1'b0;
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Testbench for wb_cmd_master: directed transfers with a response scoreboard.
// The stimulus pushes the expected {err, dat} of each request; a monitor pops
// and compares whenever a response handshake happens.
module tb_wb_cmd_master;

  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_adr = 32'd0;
  logic [31:0] req_dat = 32'd0;
  logic [3:0]  req_sel = 4'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i = 32'h5555_AAAA;
  logic        ack_drv = 1'b0;
  logic        auto_ack = 1'b0;

  int total = 0;
  int bad = 0;
  logic [32:0] exp_q[$];

  assign wbm_ack_i = ack_drv | (auto_ack & wbm_cyc_o & wbm_stb_o);

  always #5 clk = ~clk;

  wb_cmd_master #(.TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_adr  (req_adr),
    .req_dat  (req_dat),
    .req_sel  (req_sel),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i),
    .wbm_dat_i(wbm_dat_i)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: pops the scoreboard on every response handshake.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("sb_rsp_dat", rsp_dat, e[31:0]);
        check("sb_rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // One full transfer. ack_at = BUS cycle on which the slave acks (0 = never).
  task automatic do_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int ack_at, input logic [31:0] rdat,
                        input int hold, input bit stray);
    int n;
    int k;
    logic [31:0] edat;
    logic eerr;
    bit bus_ok;
    bit stable_ok;
    edat = (ack_at == 0 || we) ? 32'd0 : rdat;
    eerr = (ack_at == 0);
    k = 0;
    while (!req_ready && k < 50) begin
      tick();
      k++;
    end
    check("req_ready_before", {31'd0, req_ready}, 32'd1);
    req_we = we; req_adr = adr; req_dat = dat; req_sel = sel; req_valid = 1'b1;
    exp_q.push_back({eerr, edat});
    tick();
    // Scramble the request inputs: the bus must keep the latched values.
    req_valid = 1'b0; req_we = ~we; req_adr = ~adr; req_dat = ~dat; req_sel = ~sel;
    n = 0;
    bus_ok = 1'b1;
    while (wbm_cyc_o && n < 300) begin
      n++;
      if (wbm_stb_o !== 1'b1 || wbm_we_o !== we || wbm_adr_o !== adr ||
          wbm_sel_o !== sel || wbm_dat_o !== dat)
        bus_ok = 1'b0;
      if (n == ack_at) begin
        ack_drv = 1'b1;
        wbm_dat_i = rdat;
      end
      tick();
      ack_drv = 1'b0;
      wbm_dat_i = 32'h5555_AAAA;
    end
    check("bus_fields", {31'd0, bus_ok}, 32'd1);
    check("cyc_cycles", n, (ack_at == 0) ? TIMEOUT : ack_at);
    check("stb_dropped", {31'd0, wbm_stb_o}, 32'd0);
    check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rsp_dat", rsp_dat, edat);
    check("rsp_err", {31'd0, rsp_err}, {31'd0, eerr});
    check("req_ready_resp", {31'd0, req_ready}, 32'd0);
    stable_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (stray && i == 1) ack_drv = 1'b1;
      tick();
      ack_drv = 1'b0;
      if (rsp_valid !== 1'b1 || rsp_dat !== edat || rsp_err !== eerr ||
          req_ready !== 1'b0 || wbm_cyc_o !== 1'b0)
        stable_ok = 1'b0;
    end
    check("resp_stable", {31'd0, stable_ok}, 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_valid_clr", {31'd0, rsp_valid}, 32'd0);
    check("req_ready_gap", {31'd0, req_ready}, 32'd0);
    tick();
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int acc;
    int last_acc;
    bit gap_ok;
    bit resp_ok;

    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    check("rst_rsp", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'd0);
    check("rst_bus", wbm_adr_o | wbm_dat_o | {27'd0, wbm_sel_o, wbm_we_o}, 32'd0);
    rst = 1'b0;
    tick();

    // Write acked on the 2nd bus cycle.
    do_req(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 2, 32'h0BAD_F00D, 0, 1'b0);
    // Read acked with data.
    do_req(1'b0, 32'h3000_0000, 32'h0000_0000, 4'hF, 1, 32'h1234_5678, 0, 1'b0);
    // Read with no ack: timeout.
    do_req(1'b0, 32'h3000_0008, 32'h0000_0000, 4'h3, 0, 32'h0, 0, 1'b0);
    // Ack coinciding with the last timeout cycle counts as an ack.
    do_req(1'b0, 32'h3000_000C, 32'h0000_0000, 4'hC, TIMEOUT, 32'hA1B2_C3D4, 0, 1'b0);
    // Response back-pressure for 5 cycles with a stray ack in RESP.
    do_req(1'b0, 32'h3000_0010, 32'h0000_0000, 4'h1, 3, 32'h7777_0001, 5, 1'b1);

    // Stray acks in IDLE.
    ack_drv = 1'b1;
    tick();
    ack_drv = 1'b0;
    tick();
    check("idle_stray_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    check("idle_stray_rsp", {31'd0, rsp_valid}, 32'd0);
    check("idle_stray_ready", {31'd0, req_ready}, 32'd1);

    // Reset on the 3rd bus cycle aborts without a response.
    req_we = 1'b0; req_adr = 32'h3000_0020; req_sel = 4'hF; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check("pre_rst_cyc", {31'd0, wbm_cyc_o}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    check("rst_mid_rsp", {31'd0, rsp_valid}, 32'd0);
    resp_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) resp_ok = 1'b0;
    end
    check("rst_no_rsp", {31'd0, resp_ok}, 32'd1);
    do_req(1'b1, 32'h3000_0024, 32'hCAFE_0001, 4'h6, 1, 32'h0, 0, 1'b0);

    // Throughput: zero-wait ack, rsp_ready high, request always pending.
    auto_ack = 1'b1;
    rsp_ready = 1'b1;
    wbm_dat_i = 32'hCAFE_F00D;
    req_we = 1'b0; req_adr = 32'h3000_0030; req_sel = 4'hF; req_valid = 1'b1;
    acc = 0;
    last_acc = -1;
    gap_ok = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (req_ready) begin
        exp_q.push_back({1'b0, 32'hCAFE_F00D});
        if (last_acc >= 0 && i - last_acc != 4) gap_ok = 1'b0;
        last_acc = i;
        acc++;
      end
      tick();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("tput_count", acc, 5);
    check("tput_gap", {31'd0, gap_ok}, 32'd1);
    auto_ack = 1'b0;
    rsp_ready = 1'b0;

    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
